// File: rtl/alits_pkg.sv
// Shared definitions for the SAR controller slice.
//   state_e            : controller phase (IDLE, SAMPLE, CONVERT)
//   *_DEF              : default resolution and phase lengths
//   clog2()            : ceiling log2 for sizing counters/indices
package alits_pkg;

  localparam int unsigned N_BITS_DEF        = 8;
  localparam int unsigned SAMPLE_CYCLES_DEF = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/alits_sync2.sv
// Two-flop synchronizer for the asynchronous comparator decision.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (both flops clear to 0)
//   d     : asynchronous input
//   q     : synchronized output, two clocks of latency
module alits_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/alits_sar_ctrl.sv
// Successive-approximation controller: samples, then binary-searches the
// DAC code MSB first using the synchronized comparator decision.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : tile enable; low aborts to IDLE
//   start      : conversion request (honoured only in IDLE)
//   cmp_in     : raw comparator (1 = Vin >= Vdac), asynchronous
//   sample     : sample switch control (registered)
//   dac_code   : trial code to the DAC (registered)
//   busy       : high from first SAMPLE cycle through last bit trial
//   done       : one-cycle pulse when result is updated
//   result     : last completed conversion
module alits_sar_ctrl
  import alits_pkg::*;
#(
  parameter int unsigned N_BITS        = N_BITS_DEF,
  parameter int unsigned SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              cmp_in,
  output logic              sample,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW      = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam int unsigned IW      = (clog2(N_BITS) < 1) ? 1 : clog2(N_BITS);

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MSB     = IW'(N_BITS - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_BITS-1:0] code_q, code_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic              sample_q, sample_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_BITS-1:0] decided;
  logic              cmp_sync;

  alits_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_sync)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    code_d   = code_q;
    result_d = result_q;
    sample_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    // Current trial code with bit idx resolved by the comparator.
    decided          = code_q;
    decided[idx_q]   = cmp_sync;

    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      code_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          code_d = '0;
          if (start) begin
            state_d  = SAMPLE;
            cnt_d    = '0;
            sample_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
        SAMPLE: begin
          busy_d = 1'b1;
          code_d = '0;
          if (cnt_q == SAMPLE_LAST) begin
            state_d         = CONVERT;
            cnt_d           = '0;
            idx_d           = IDX_MSB;
            code_d[IDX_MSB] = 1'b1;
          end else begin
            sample_d = 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end
        end
        CONVERT: begin
          busy_d = 1'b1;
          if (cnt_q == SETTLE_LAST) begin
            cnt_d = '0;
            if (idx_q == '0) begin
              state_d  = IDLE;
              result_d = decided;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              code_d   = '0;
            end else begin
              idx_d                = idx_q - 1'b1;
              code_d               = decided;
              code_d[idx_q - 1'b1] = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          code_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      result_q <= result_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sample   = sample_q;
  assign dac_code = code_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_alits_sar_ctrl.sv
module tb_alits_sar_ctrl;

  localparam int N = 8;
  localparam int S = 4;
  localparam int T = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b1;
  logic       start  = 1'b0;
  logic       cmp_in = 1'b0;
  logic       sample, busy, done;
  logic [7:0] dac_code, result;
  logic [7:0] vin = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] trials [8];
  int         ntr = 0;

  alits_sar_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .cmp_in   (cmp_in),
    .sample   (sample),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Ideal comparator, one cycle behind the DAC code.
  always @(posedge clk) cmp_in <= (vin >= dac_code);

  // Model: t counts cycles since acceptance; an ideal binary search
  // ends on vin, so every trial code is vin's upper bits plus the trial bit.
  typedef struct {
    bit         a;
    int         t;
    logic [7:0] r;
    bit         d;
  } mstate_t;

  mstate_t m = '{a: 1'b0, t: 0, r: 8'h00, d: 1'b0};

  function automatic mstate_t step(mstate_t s, logic en, logic st, logic [7:0] v);
    mstate_t n;
    n   = s;
    n.d = 1'b0;
    if (!en) n.a = 1'b0;
    else if (s.a) begin
      n.t = s.t + 1;
      if (n.t == S + N * T) begin
        n.a = 1'b0;
        n.d = 1'b1;
        n.r = v;
      end
    end else if (st) begin
      n.a = 1'b1;
      n.t = 0;
    end
    return n;
  endfunction

  function automatic logic [7:0] trial_code(logic [7:0] v, int t);
    int i, hi;
    i  = N - 1 - (t - S) / T;
    hi = (int'(v) >> (i + 1)) << (i + 1);
    return 8'(hi | (1 << i));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{a: 1'b0, t: 0, r: 8'h00, d: 1'b0};
    else        m <= step(m, ena, start, vin);
  end

  logic       e_sample, e_busy, e_done;
  logic [7:0] e_dac, e_res;
  assign e_busy   = m.a;
  assign e_sample = m.a && (m.t < S);
  assign e_dac    = (m.a && m.t >= S) ? trial_code(vin, m.t) : 8'h00;
  assign e_done   = m.d;
  assign e_res    = m.r;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sample", int'(sample), int'(e_sample));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("dac_code", int'(dac_code), int'(e_dac));
      chk("result", int'(result), int'(e_res));
    end
  end

  // One conversion; n counts negedges from the cycle start is presented.
  task automatic conv(input logic [7:0] v, input int rp1, input int rp2,
                      output int lat, output int bc, output logic [7:0] res);
    vin = v;
    ntr = 0;
    lat = -1;
    bc  = 0;
    res = 8'h00;
    @(posedge clk); #1 start = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy) bc++;
      if (busy && !sample && ntr < 8 && (ntr == 0 || dac_code != trials[ntr-1])) begin
        trials[ntr] = dac_code;
        ntr++;
      end
      if (done) begin
        lat = n;
        res = result;
        break;
      end
      @(posedge clk); #1 start = ((n + 1) == rp1) || ((n + 1) == rp2);
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bc, nd, d1, d2;
    logic [7:0] res;
    logic [7:0] exp_tr [8];
    exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dac", int'(dac_code), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_sample", int'(sample), 0);
    chk_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    conv(8'hA5, -1, -1, lat, bc, res);
    chk("a5_latency", lat, 37);
    chk("a5_busy_cycles", bc, 36);
    chk("a5_result", int'(res), 'hA5);
    chk("a5_trial_count", ntr, 8);
    for (int i = 0; i < 8; i++) chk("a5_trial", int'(trials[i]), int'(exp_tr[i]));

    conv(8'hFF, -1, -1, lat, bc, res);
    chk("ff_result", int'(res), 'hFF);
    chk("ff_busy_cycles", bc, 36);
    conv(8'h00, -1, -1, lat, bc, res);
    chk("00_result", int'(res), 'h00);
    chk("00_busy_cycles", bc, 36);

    conv(8'hA5, 5, 20, lat, bc, res);
    chk("repulse_latency", lat, 37);
    chk("repulse_result", int'(res), 'hA5);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("repulse_extra_done", nd, 0);

    // Reset in the middle of a conversion.
    vin = 8'h5A;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sample", int'(sample), 0);
    chk("midrst_dac", int'(dac_code), 0);
    chk("midrst_result", int'(result), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    conv(8'hA5, -1, -1, lat, bc, res);
    chk("restart_result", int'(res), 'hA5);
    chk("restart_latency", lat, 37);

    // ena dropped at conversion cycle 10.
    vin = 8'h33;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 ena = 1'b0;
    @(negedge clk);
    chk("ena_drop_same_cycle_busy", int'(busy), 1);
    @(negedge clk);
    chk("ena_abort_busy", int'(busy), 0);
    chk("ena_abort_dac", int'(dac_code), 0);
    nd = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ena_abort_done", nd, 0);
    chk("ena_abort_result", int'(result), 'hA5);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("ena_low_start_ignored", int'(busy), 0);
    @(posedge clk); #1 ena = 1'b1;

    // start held high: back-to-back conversions.
    vin = 8'h3C;
    d1 = -1;
    d2 = -1;
    @(posedge clk); #1 start = 1'b1;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_latency", d1, 37);
    chk("b2b_spacing", d2 - d1, 37);
    chk("b2b_result", int'(result), 'h3C);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
